// File: rtl/ber_pkg.sv
// ber_pkg: shared state encoding and constants for the channel BER meter
package ber_pkg;
   typedef enum logic [1:0] {IDLE, MEASURE, DRAIN, DONE} state_t;
   localparam int DEF_DATA_W   = 32;
   localparam int DRAIN_CYCLES = 2;
endpackage

// File: rtl/channel_ber_meter_if.sv
// channel_ber_meter_if: control, sample and result signals of the BER meter
interface channel_ber_meter_if #(
   parameter int DATA_W   = 32,
   parameter int WIN_LOG2 = 10
) ();
   logic                start;
   logic                valid;
   logic [DATA_W-1:0]   y_ref;
   logic [DATA_W-1:0]   y_rx;
   logic                busy;
   logic                done;
   logic [WIN_LOG2+5:0] bit_err_cnt;
   logic [WIN_LOG2:0]   word_err_cnt;
   logic [WIN_LOG2:0]   max_burst;
   modport master (output start, valid, y_ref, y_rx,
                   input  busy, done, bit_err_cnt, word_err_cnt, max_burst);
   modport slave  (input  start, valid, y_ref, y_rx,
                   output busy, done, bit_err_cnt, word_err_cnt, max_burst);
endinterface

// File: rtl/popcount_w.sv
// popcount_w: combinational population count of a DATA_W-bit word
module popcount_w #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]         data_i,
   output logic [$clog2(DATA_W):0]   count_o
);
   // add up every set bit
   always_comb begin
      count_o = '0;
      for (int i = 0; i < DATA_W; i++) count_o = count_o + {{$clog2(DATA_W){1'b0}}, data_i[i]};
   end
endmodule

// File: rtl/channel_ber_meter.sv
// channel_ber_meter: windowed bit/word error counter between clean and noisy words; BER_BURST_TRACK_EN adds longest-error-run tracking
module channel_ber_meter
   import ber_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WIN_LOG2 = 10
) (
   input logic                 clk,
   input logic                 reset,
   channel_ber_meter_if.slave  bus
);
   localparam int PW = $clog2(DATA_W) + 1;
   localparam int BW = WIN_LOG2 + 6;
   localparam int CW = WIN_LOG2 + 1;
   localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              drain_q, drain_d;
   logic              s1_vld_q, s2_vld_q, s2_err_q;
   logic [DATA_W-1:0] s1_diff_q;
   logic [PW-1:0]     pop, s2_pop_q;
   logic [BW-1:0]     bit_q;
   logic [CW-1:0]     word_q;
   logic              accept, go;

   assign accept = bus.valid && state_q == MEASURE;
   assign go     = bus.start && (state_q == IDLE || state_q == DONE);

   popcount_w #(.DATA_W(DATA_W)) u_pop (.data_i(s1_diff_q), .count_o(pop));

   // next state, window sample counter and drain timer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      unique case (state_q)
         IDLE, DONE: if (go) begin
            state_d = MEASURE;
            cnt_d   = '0;
         end
         MEASURE: if (accept) begin
            cnt_d   = cnt_q + 1'b1;
            drain_d = 1'b0;
            state_d = cnt_q == LAST ? DRAIN : MEASURE;
         end
         DRAIN: begin
            drain_d = drain_q + 1'b1;
            state_d = drain_q == 1'(DRAIN_CYCLES - 1) ? DONE : DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end

   // two-stage compare pipeline: xor, then popcount and any-error flag
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         s1_vld_q  <= 1'b0;
         s1_diff_q <= '0;
         s2_vld_q  <= 1'b0;
         s2_pop_q  <= '0;
         s2_err_q  <= 1'b0;
      end else begin
         s1_vld_q  <= accept && !go;
         s1_diff_q <= bus.y_ref ^ bus.y_rx;
         s2_vld_q  <= s1_vld_q && !go;
         s2_pop_q  <= pop;
         s2_err_q  <= |s1_diff_q;
      end

   // accumulate retiring stage-2 results; a new start clears them
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         bit_q  <= '0;
         word_q <= '0;
      end else if (go) begin
         bit_q  <= '0;
         word_q <= '0;
      end else if (s2_vld_q) begin
         bit_q  <= bit_q + BW'(s2_pop_q);
         word_q <= word_q + CW'(s2_err_q);
      end

`ifdef BER_BURST_TRACK_EN
   logic [CW-1:0] run_q, run_d, max_q;
   assign run_d = s2_err_q ? run_q + 1'b1 : '0;

   // current error run and the longest seen in this window
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         run_q <= '0;
         max_q <= '0;
      end else if (go) begin
         run_q <= '0;
         max_q <= '0;
      end else if (s2_vld_q) begin
         run_q <= run_d;
         max_q <= run_d > max_q ? run_d : max_q;
      end

   assign bus.max_burst = max_q;
`else
   assign bus.max_burst = '0;
`endif

   assign bus.busy         = state_q == MEASURE || state_q == DRAIN;
   assign bus.done         = state_q == DONE;
   assign bus.bit_err_cnt  = bit_q;
   assign bus.word_err_cnt = word_q;
endmodule
